// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter that shares one single-port synchronous RAM between
// NCORES requesters. One transaction is in flight at a time, with a req/ack handshake per core.
module mem_rr_arbiter #(
    parameter int NCORES = 2,
    parameter int AW     = 8,
    parameter int DW     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCORES-1:0]    req,
    input  logic [NCORES-1:0]    wr,
    input  logic [NCORES*AW-1:0] addr,
    input  logic [NCORES*DW-1:0] din,
    input  logic [DW-1:0]        ram_q,
    output logic [AW-1:0]        ram_addr,
    output logic [DW-1:0]        ram_din,
    output logic                 ram_wren,
    output logic [NCORES-1:0]    grant,
    output logic [NCORES-1:0]    ack,
    output logic [DW-1:0]        dq,
    output logic                 busy
);

    localparam int IW = (NCORES > 1) ? $clog2(NCORES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2,
        ACK    = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic [IW-1:0]      last_r, last_s;
    logic [IW-1:0]      win_r, win_s;
    logic [IW-1:0]      pick_s, idx_s;
    logic               found_s;
    logic [NCORES-1:0]  grant_r, grant_s;
    logic [NCORES-1:0]  ack_r, ack_s;
    logic [AW-1:0]      ram_addr_r, ram_addr_s;
    logic [DW-1:0]      ram_din_r, ram_din_s;
    logic               ram_wren_r, ram_wren_s;
    logic [DW-1:0]      dq_r, dq_s;
    logic               busy_r, busy_s;

    // Round-robin search: first requesting core above the last owner, with wrap
    always_comb begin
        pick_s  = '0;
        idx_s   = '0;
        found_s = 1'b0;
        for (int k = 1; k <= NCORES; k++) begin
            idx_s = IW'((int'(last_r) + k) % NCORES);
            if (!found_s && req[idx_s]) begin
                found_s = 1'b1;
                pick_s  = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state and next-output logic of the transaction FSM
    always_comb begin
        state_s    = state_r;
        last_s     = last_r;
        win_s      = win_r;
        grant_s    = grant_r;
        ack_s      = ack_r;
        ram_addr_s = ram_addr_r;
        ram_din_s  = ram_din_r;
        ram_wren_s = ram_wren_r;
        dq_s       = dq_r;
        busy_s     = busy_r;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    win_s      = pick_s;
                    ram_addr_s = addr[int'(pick_s)*AW +: AW];
                    ram_din_s  = din[int'(pick_s)*DW +: DW];
                    ram_wren_s = wr[pick_s];
                    grant_s    = NCORES'(1) << pick_s;
                    busy_s     = 1'b1;
                    state_s    = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                // ram_wren_r still holds the owner's direction during ISSUE
                ram_wren_s = 1'b0;
                if (ram_wren_r) begin
                    ack_s   = grant_r;
                    state_s = ACK;
                end else begin
                    state_s = RDWAIT;
                end
            end
            RDWAIT: begin
                dq_s    = ram_q;
                ack_s   = grant_r;
                state_s = ACK;
            end
            ACK: begin
                ack_s   = '0;
                grant_s = '0;
                busy_s  = 1'b0;
                last_s  = win_r;
                state_s = IDLE;
            end
            default: begin
                ram_wren_s = 1'b0;
                ack_s      = '0;
                grant_s    = '0;
                busy_s     = 1'b0;
                state_s    = IDLE;
            end
        endcase
    end

    // State and output registers; reset gives core 0 top priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            last_r     <= IW'(NCORES - 1);
            win_r      <= '0;
            grant_r    <= '0;
            ack_r      <= '0;
            ram_addr_r <= '0;
            ram_din_r  <= '0;
            ram_wren_r <= 1'b0;
            dq_r       <= '0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            last_r     <= last_s;
            win_r      <= win_s;
            grant_r    <= grant_s;
            ack_r      <= ack_s;
            ram_addr_r <= ram_addr_s;
            ram_din_r  <= ram_din_s;
            ram_wren_r <= ram_wren_s;
            dq_r       <= dq_s;
            busy_r     <= busy_s;
        end
    end

    assign ram_addr = ram_addr_r;
    assign ram_din  = ram_din_r;
    assign ram_wren = ram_wren_r;
    assign grant    = grant_r;
    assign ack      = ack_r;
    assign dq       = dq_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed, scoreboard-based bench for mem_rr_arbiter: a 2-core instance with a
// RAM model, plus a 4-core instance used to check the round-robin grant order.
module tb_mem_rr_arbiter;

    typedef struct {
        logic [1:0] ack;
        logic       rd;
        logic [7:0] adr;
        logic [7:0] dat;
        int         lat;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [1:0]  req, wr;
    logic [15:0] addr, din;
    logic [7:0]  ram_q, ram_addr, ram_din, dq;
    logic        ram_wren, busy;
    logic [1:0]  grant, ack;

    logic [3:0]  req4, wr4, grant4, ack4;
    logic [31:0] addr4, din4;
    logic [7:0]  ram_q4 = 8'h00;
    logic [7:0]  ram_addr4, ram_din4, dq4;
    logic        ram_wren4, busy4;

    logic [7:0]  mem [256] = '{default: 8'h00};

    exp_t        sb[$];
    logic [3:0]  sb4[$];
    int          n_cmp = 0;
    int          n_err = 0;

    mem_rr_arbiter #(.NCORES(2), .AW(8), .DW(8)) dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .din(din),
        .ram_q(ram_q), .ram_addr(ram_addr), .ram_din(ram_din), .ram_wren(ram_wren),
        .grant(grant), .ack(ack), .dq(dq), .busy(busy)
    );

    mem_rr_arbiter #(.NCORES(4), .AW(8), .DW(8)) dut4 (
        .clk(clk), .rst(rst), .req(req4), .wr(wr4), .addr(addr4), .din(din4),
        .ram_q(ram_q4), .ram_addr(ram_addr4), .ram_din(ram_din4), .ram_wren(ram_wren4),
        .grant(grant4), .ack(ack4), .dq(dq4), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM with one-cycle registered read
    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_din;
        ram_q <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic expect_txn(input logic [1:0] a, input logic r, input logic [7:0] ad,
                              input logic [7:0] d, input int l);
        exp_t e;
        e.ack = a; e.rd = r; e.adr = ad; e.dat = d; e.lat = l;
        sb.push_back(e);
    endtask

    // Wait (bounded) for the next ack on the 2-core DUT and score it against the queue head
    task automatic await_ack(input string tag, input logic wd_en, input logic [1:0] wd_req);
        int         cyc = 0;
        int         pulses = 0;
        logic [1:0] a = 2'b00;
        logic [7:0] wa = 8'h00;
        logic [7:0] wd = 8'h00;
        exp_t       e;
        while (a == 2'b00 && cyc < 12) begin
            @(negedge clk);
            cyc++;
            if (ram_wren) begin
                pulses++;
                wa = ram_addr;
                wd = ram_din;
            end
            a = ack;
            if (wd_en && cyc == 1) req = wd_req;
        end
        chk({tag, " pending"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, " ack"}, a, e.ack);
            chk({tag, " grant"}, grant, e.ack);
            chk({tag, " busy"}, busy, 1);
            chk({tag, " latency"}, cyc, e.lat);
            chk({tag, " wren_pulses"}, pulses, e.rd ? 0 : 1);
            if (e.rd) begin
                chk({tag, " dq"}, dq, e.dat);
            end else begin
                chk({tag, " ram_addr"}, wa, e.adr);
                chk({tag, " ram_din"}, wd, e.dat);
            end
        end
    endtask

    // Wait (bounded) for the next ack on the 4-core DUT and check the owner order
    task automatic await4(input string tag);
        int         cyc = 0;
        logic [3:0] a = 4'b0000;
        logic [3:0] e;
        while (a == 4'b0000 && cyc < 10) begin
            @(negedge clk);
            cyc++;
            a = ack4;
        end
        chk({tag, " pending"}, 32'(sb4.size() > 0), 32'd1);
        if (sb4.size() > 0) begin
            e = sb4.pop_front();
            chk({tag, " ack4"}, a, e);
            chk({tag, " grant4"}, grant4, e);
        end
    endtask

    initial begin
        int n_wren = 0;
        int n_ack  = 0;
        rst = 1'b1; req = 2'b00; wr = 2'b00; addr = 16'h0000; din = 16'h0000;
        req4 = 4'b0000; wr4 = 4'b1111; addr4 = 32'h33221100; din4 = 32'hDDCCBBAA;
        @(negedge clk);
        @(negedge clk);
        chk("rst grant", grant, 0);
        chk("rst ack", ack, 0);
        chk("rst ram_wren", ram_wren, 0);
        chk("rst ram_addr", ram_addr, 0);
        chk("rst ram_din", ram_din, 0);
        chk("rst dq", dq, 0);
        chk("rst busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single write from core 0
        req = 2'b01; wr = 2'b01; addr = 16'h0012; din = 16'h00A5;
        expect_txn(2'b01, 1'b0, 8'h12, 8'hA5, 2);
        await_ack("wr0", 1'b0, 2'b00);
        req = 2'b00;
        @(negedge clk);
        chk("idle busy", busy, 0);
        chk("idle grant", grant, 0);
        chk("idle ack", ack, 0);

        // Read-back from core 1
        req = 2'b10; wr = 2'b00; addr = 16'h1200;
        expect_txn(2'b10, 1'b1, 8'h12, 8'hA5, 3);
        await_ack("rd1", 1'b0, 2'b00);
        req = 2'b00;
        @(negedge clk);
        chk("rd1 dq hold", dq, 8'hA5);

        // Contention: core 0 writes, core 1 reads, both hold req
        req = 2'b11; wr = 2'b01; addr = 16'h0101; din = 16'h0011;
        expect_txn(2'b01, 1'b0, 8'h01, 8'h11, 2);
        expect_txn(2'b10, 1'b1, 8'h01, 8'h11, 4);
        expect_txn(2'b01, 1'b0, 8'h02, 8'h22, 3);
        expect_txn(2'b10, 1'b1, 8'h02, 8'h22, 4);
        await_ack("cont1", 1'b0, 2'b00);
        addr[7:0] = 8'h02; din[7:0] = 8'h22;
        await_ack("cont2", 1'b0, 2'b00);
        addr[15:8] = 8'h02;
        await_ack("cont3", 1'b0, 2'b00);
        await_ack("cont4", 1'b0, 2'b00);
        req = 2'b00;
        @(negedge clk);
        chk("cont mem02", mem[8'h02], 8'h22);

        // Withdrawal: core 0 drops after grant, core 1 pulses req while busy
        wr = 2'b11; addr = 16'h4030; din = 16'hEE5A;
        req = 2'b01;
        expect_txn(2'b01, 1'b0, 8'h30, 8'h5A, 2);
        await_ack("wdraw", 1'b1, 2'b10);
        req = 2'b00;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ram_wren) n_wren++;
            if (ack != 2'b00) n_ack++;
        end
        chk("wdraw core1 wren", n_wren, 0);
        chk("wdraw core1 ack", n_ack, 0);
        chk("wdraw mem40", mem[8'h40], 8'h00);
        chk("wdraw mem30", mem[8'h30], 8'h5A);

        // Reset during RDWAIT of a core 0 read
        wr = 2'b00; addr = 16'h0030;
        req = 2'b01;
        @(negedge clk);
        @(negedge clk);
        chk("mid busy", busy, 1);
        chk("mid ack", ack, 0);
        rst = 1'b1;
        #1;
        chk("mid rst grant", grant, 0);
        chk("mid rst ack", ack, 0);
        chk("mid rst ram_wren", ram_wren, 0);
        chk("mid rst busy", busy, 0);
        chk("mid rst dq", dq, 0);
        chk("mid rst ram_addr", ram_addr, 0);
        req = 2'b00;
        @(negedge clk);
        chk("mid rst no ack", ack, 0);
        rst = 1'b0;
        @(negedge clk);

        // Priority restored: core 0 first, then core 1
        req = 2'b11; wr = 2'b00; addr = 16'h3002;
        expect_txn(2'b01, 1'b1, 8'h02, 8'h22, 3);
        expect_txn(2'b10, 1'b1, 8'h30, 8'h5A, 4);
        await_ack("post1", 1'b0, 2'b00);
        await_ack("post2", 1'b0, 2'b00);
        req = 2'b00;
        @(negedge clk);

        // Fairness with 4 cores: core 2 goes first alone, then all request
        req4 = 4'b0100;
        sb4.push_back(4'b0100);
        await4("f4 solo");
        req4 = 4'b0000;
        @(negedge clk);
        req4 = 4'b1111;
        sb4.push_back(4'b1000);
        sb4.push_back(4'b0001);
        sb4.push_back(4'b0010);
        sb4.push_back(4'b0100);
        for (int i = 0; i < 4; i++) begin
            await4("f4 rr");
            if (i == 3) req4 = 4'b0000;
        end
        @(negedge clk);
        chk("f4 idle busy", busy4, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
